dl_mem_writer: RTL and testbench

Parametrised download-to-memory write bridge between the hps_io ioctl download port and a toggle-handshake memory writer (ddram-style `we_req`/`we_ack`). Packs IN_W-bit ioctl words into OUT_W-bit memory words with byte enables and buffers them in a small FIFO. It drives `ioctl_wait` for backpressure and flushes partial words when a download ends. It generalises the single-word toggle loader to arbitrary widths, sparse addresses and multiple outstanding words.

---
 rtl/dl_mem_writer_if.sv | 41 ++++
 rtl/dl_mem_writer.sv | 204 ++++++++++++++++++++
 tb/tb_dl_mem_writer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dl_mem_writer_if.sv
// rtl/dl_mem_writer_if.sv - ioctl download port plus toggle-handshake memory write port
//
// Purpose: bundles the hps_io ioctl download signals and the we_req/we_ack style
// memory write signals used by dl_mem_writer.
// Ports (slave = the bridge, master = the host/memory side):
//   ioctl_download, ioctl_wr, ioctl_addr[ADDR_W], ioctl_dout[IN_W]  host -> bridge
//   ioctl_wait                                                      bridge -> host
//   mem_addr[WA_W], mem_din[OUT_W], mem_be[BE_W], mem_req           bridge -> memory
//   mem_ack                                                         memory -> bridge
//   done                                                            bridge -> host

interface dl_mem_writer_if #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 64,
    parameter int ADDR_W = 25
);
    localparam int BE_W = OUT_W / 8;
    localparam int WA_W = ADDR_W - $clog2(BE_W);

    logic              ioctl_download;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [IN_W-1:0]   ioctl_dout;
    logic              ioctl_wait;
    logic [WA_W-1:0]   mem_addr;
    logic [OUT_W-1:0]  mem_din;
    logic [BE_W-1:0]   mem_be;
    logic              mem_req;
    logic              mem_ack;
    logic              done;

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
        output ioctl_wait, mem_addr, mem_din, mem_be, mem_req, done
    );

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
        input  ioctl_wait, mem_addr, mem_din, mem_be, mem_req, done
    );
endinterface

// File: rtl/dl_mem_writer.sv
// rtl/dl_mem_writer.sv - ioctl download to toggle-handshake memory write bridge
//
// Purpose: packs IN_W-bit ioctl writes into OUT_W-bit memory words with byte
// enables, buffers them in a FIFO_DEPTH-entry FIFO and drains them through a
// toggle request/acknowledge handshake. Partial words are flushed when the
// download ends; done pulses once everything has been written.
// Optional feature macro: DL_MEM_WRITER_BYTESWAP_EN swaps the two bytes of each
// 16-bit ioctl word before merging (no effect with IN_W=8).
// Ports:
//   clk_sys  system clock, rising edge
//   reset    asynchronous, active-high
//   bus      dl_mem_writer_if.slave (ioctl download side + memory write side)

module dl_mem_writer #(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 64,
    parameter int ADDR_W     = 25,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk_sys,
    input  logic            reset,
    dl_mem_writer_if.slave  bus
);
    localparam int BE_W = OUT_W / 8;
    localparam int IB   = IN_W / 8;
    localparam int BO   = $clog2(BE_W);
    localparam int BO_W = (BO > 0) ? BO : 1;
    localparam int WA_W = ADDR_W - BO;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam logic [BE_W-1:0] LANE_BE0 = BE_W'((1 << IB) - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t            state, state_n;
    logic              issue;

    logic              dl_q;
    logic [WA_W-1:0]   acc_addr;
    logic [OUT_W-1:0]  acc_data;
    logic [BE_W-1:0]   acc_be;
    logic              acc_full;
    logic              flush_pend;
    logic              done_pend;

    logic [WA_W-1:0]   fifo_addr [FIFO_DEPTH];
    logic [OUT_W-1:0]  fifo_data [FIFO_DEPTH];
    logic [BE_W-1:0]   fifo_be   [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;

    logic [WA_W-1:0]   mem_addr_q;
    logic [OUT_W-1:0]  mem_din_q;
    logic [BE_W-1:0]   mem_be_q;
    logic              mem_req_q;
    logic              wait_q;
    logic              done_q;

    logic [IN_W-1:0]   din_sw;
    logic              dl_rise, dl_fall, acc_live, push, pop;
    logic [WA_W-1:0]   wr_waddr;
    logic [BO_W-1:0]   boff;
    logic [BE_W-1:0]   lane_be, base_be, acc_be_n;
    logic [OUT_W-1:0]  lane_data, lane_bits, base_data, acc_data_n;
    logic [WA_W-1:0]   acc_addr_n;
    logic              acc_full_n, flush_pend_n, done_fire, done_pend_n, wait_n;
    logic [CW-1:0]     count_n;

    assign bus.ioctl_wait = wait_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.done       = done_q;

`ifdef DL_MEM_WRITER_BYTESWAP_EN
    assign din_sw = {<<8{bus.ioctl_dout}};
`else
    assign din_sw = bus.ioctl_dout;
`endif

    // Drain FSM: one outstanding memory word per toggle round trip.
    always_comb begin
        state_n = state;
        issue   = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    issue   = 1'b1;
                    state_n = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.mem_ack == mem_req_q) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Accumulator / FIFO bookkeeping.
    always_comb begin
        dl_rise  = bus.ioctl_download & ~dl_q;
        dl_fall  = ~bus.ioctl_download & dl_q;
        // A new download discards whatever the accumulator still holds.
        acc_live = (|acc_be) & ~dl_rise;
        wr_waddr = bus.ioctl_addr[ADDR_W-1:BO];

        if (BO > 0) boff = bus.ioctl_addr[BO_W-1:0] & ~BO_W'(IB - 1);
        else        boff = '0;

        lane_be   = LANE_BE0 << boff;
        lane_data = OUT_W'(din_sw) << {boff, 3'b000};
        lane_bits = OUT_W'({IN_W{1'b1}}) << {boff, 3'b000};

        // Full words, pending flushes and address changes all push the same
        // accumulator, so there is never more than one push per cycle.
        push = acc_live & (acc_full | flush_pend |
                           (bus.ioctl_wr & (wr_waddr != acc_addr)));

        base_data = acc_data;
        base_be   = acc_be;
        if (push || !acc_live) begin
            base_data = '0;
            base_be   = '0;
        end

        acc_addr_n = acc_addr;
        acc_data_n = base_data;
        acc_be_n   = base_be;
        if (bus.ioctl_wr) begin
            acc_addr_n = wr_waddr;
            acc_data_n = (base_data & ~lane_bits) | lane_data;
            acc_be_n   = base_be | lane_be;
        end
        acc_full_n = &acc_be_n;

        // A write merged in the falling-edge cycle is flushed the cycle after.
        flush_pend_n = (flush_pend | dl_fall) & (|acc_be_n) & ~dl_rise;

        pop     = issue;
        count_n = count + CW'(push) - CW'(pop);
        wait_n  = acc_full_n | (count_n > CW'(FIFO_DEPTH - 2)) | flush_pend_n;

        done_fire   = done_pend & ~(|acc_be) & ~flush_pend & (count == '0) &
                      (state == S_IDLE) & (bus.mem_ack == mem_req_q);
        done_pend_n = (done_pend & ~done_fire & ~dl_rise) | dl_fall;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_q       <= 1'b0;
            acc_addr   <= '0;
            acc_data   <= '0;
            acc_be     <= '0;
            acc_full   <= 1'b0;
            flush_pend <= 1'b0;
            done_pend  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            wait_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            dl_q       <= bus.ioctl_download;
            acc_addr   <= acc_addr_n;
            acc_data   <= acc_data_n;
            acc_be     <= acc_be_n;
            acc_full   <= acc_full_n;
            flush_pend <= flush_pend_n;
            done_pend  <= done_pend_n;
            count      <= count_n;
            wait_q     <= wait_n;
            done_q     <= done_fire;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wr_ptr] <= acc_addr;
            fifo_data[wr_ptr] <= acc_data;
            fifo_be[wr_ptr]   <= acc_be;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_be_q   <= '0;
            mem_req_q  <= 1'b0;
        end else begin
            state <= state_n;
            if (issue) begin
                mem_addr_q <= fifo_addr[rd_ptr];
                mem_din_q  <= fifo_data[rd_ptr];
                mem_be_q   <= fifo_be[rd_ptr];
                mem_req_q  <= ~mem_req_q;
            end
        end
    end
endmodule

// File: tb/tb_dl_mem_writer.sv
// tb/tb_dl_mem_writer.sv - scoreboard bench for dl_mem_writer

module tb_dl_mem_writer;
    localparam int IN_W       = 16;
    localparam int OUT_W      = 64;
    localparam int ADDR_W     = 25;
    localparam int FIFO_DEPTH = 4;
    localparam int BE_W       = OUT_W / 8;
    localparam int IB         = IN_W / 8;
    localparam int WA_W       = ADDR_W - $clog2(BE_W);

    typedef struct {
        logic [WA_W-1:0]  addr;
        logic [OUT_W-1:0] data;
        logic [BE_W-1:0]  be;
    } word_t;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    dl_mem_writer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus ();

    dl_mem_writer #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    int    checks = 0;
    int    errors = 0;
    word_t exp_q[$];
    bit    ack_hold = 0;
    int    done_cnt = 0;
    int    words_seen = 0;
    bit    saw_wait = 0;
    logic [WA_W-1:0]  last_addr;
    logic [OUT_W-1:0] last_din;
    logic [BE_W-1:0]  last_be;

    // Reference model: a byte-granular picture of the word being assembled.
    logic [7:0]       m_bytes [BE_W];
    logic [BE_W-1:0]  m_be = '0;
    logic [WA_W-1:0]  m_wa = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void model_push();
        word_t w;
        w.addr = m_wa;
        w.be   = m_be;
        w.data = '0;
        for (int i = 0; i < BE_W; i++)
            if (m_be[i]) w.data[8*i +: 8] = m_bytes[i];
        exp_q.push_back(w);
        m_be = '0;
    endfunction

    function automatic void model_write(input logic [ADDR_W-1:0] a, input logic [IN_W-1:0] d);
        logic [WA_W-1:0] wa;
        int off;
        wa  = WA_W'(a / BE_W);
        off = int'(a % BE_W);
        if (m_be != '0 && wa != m_wa) model_push();
        m_wa = wa;
        for (int i = 0; i < IB; i++) begin
`ifdef DL_MEM_WRITER_BYTESWAP_EN
            m_bytes[off + i] = d[8*(IB-1-i) +: 8];
`else
            m_bytes[off + i] = d[8*i +: 8];
`endif
            m_be[off + i] = 1'b1;
        end
        if (&m_be) model_push();
    endfunction

    // Memory responder + scoreboard monitor.
    initial begin
        bus.mem_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (!reset && !ack_hold && bus.mem_req !== bus.mem_ack) begin
                word_t e;
                logic [OUT_W-1:0] m;
                words_seen++;
                last_addr = bus.mem_addr;
                last_din  = bus.mem_din;
                last_be   = bus.mem_be;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h required=none", bus.mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    m = '0;
                    for (int i = 0; i < BE_W; i++) if (e.be[i]) m[8*i +: 8] = 8'hFF;
                    check("mem_addr", 128'(bus.mem_addr), 128'(e.addr));
                    check("mem_be", 128'(bus.mem_be), 128'(e.be));
                    check("mem_din", 128'(bus.mem_din & m), 128'(e.data & m));
                end
                repeat ($urandom_range(0, 3)) @(negedge clk_sys);
                if (!reset) bus.mem_ack = bus.mem_req;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_sys);
            if (bus.done === 1'b1) done_cnt++;
            if (bus.ioctl_wait === 1'b1) saw_wait = 1'b1;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic ioctl_write(input logic [ADDR_W-1:0] a, input logic [IN_W-1:0] d);
        int guard = 0;
        while (bus.ioctl_wait && guard < 3000) begin
            tick();
            guard++;
        end
        if (guard >= 3000) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout actual=1 required=0");
        end
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        bus.ioctl_wr   = 1'b1;
        model_write(a, d);
        tick();
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic dl_begin();
        bus.ioctl_download = 1'b1;
        m_be = '0;
        tick(2);
    endtask

    task automatic dl_end();
        int d0;
        int guard = 0;
        bus.ioctl_download = 1'b0;
        if (m_be != '0) model_push();
        d0 = done_cnt;
        while (done_cnt == d0 && guard < 3000) begin
            tick();
            guard++;
        end
        check("done_pulse", 128'(done_cnt - d0), 128'(1));
        tick(4);
        check("done_single", 128'(done_cnt - d0), 128'(1));
        check("words_drained", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        int w0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        tick(3);
        check("rst_wait", 128'(bus.ioctl_wait), 128'(0));
        check("rst_req", 128'(bus.mem_req), 128'(0));
        check("rst_addr", 128'(bus.mem_addr), 128'(0));
        check("rst_din", 128'(bus.mem_din), 128'(0));
        check("rst_be", 128'(bus.mem_be), 128'(0));
        check("rst_done", 128'(bus.done), 128'(0));
        reset = 1'b0;
        tick(2);

        // Four sequential lanes fill one word.
        dl_begin();
        w0 = words_seen;
        ioctl_write(25'h0, 16'h1111);
        ioctl_write(25'h2, 16'h2222);
        ioctl_write(25'h4, 16'h3333);
        ioctl_write(25'h6, 16'h4444);
        dl_end();
        check("t1_words", 128'(words_seen - w0), 128'(1));
        check("t1_addr", 128'(last_addr), 128'(0));
        check("t1_be", 128'(last_be), 128'(8'hFF));
        check("t1_din", 128'(last_din), 128'(64'h4444_3333_2222_1111));

        // Sparse writes: address change pushes, download end flushes.
        dl_begin();
        w0 = words_seen;
        ioctl_write(25'h10, 16'hABCD);
        ioctl_write(25'h40, 16'h1234);
        dl_end();
        check("t2_words", 128'(words_seen - w0), 128'(2));
        check("t2_addr", 128'(last_addr), 128'(8));
        check("t2_be", 128'(last_be), 128'(8'h03));

        // Backpressure: hold acks while streaming 32 writes.
        dl_begin();
        w0 = words_seen;
        ack_hold = 1'b1;
        saw_wait = 1'b0;
        fork
            begin
                tick(300);
                ack_hold = 1'b0;
            end
        join_none
        for (int i = 0; i < 32; i++) ioctl_write(25'h100 + 25'(2*i), 16'($urandom));
        dl_end();
        check("t3_saw_wait", 128'(saw_wait), 128'(1));
        check("t3_words", 128'(words_seen - w0), 128'(8));

        // Randomized downloads, including one wrapping the address space.
        for (int dl = 0; dl < 6; dl++) begin
            dl_begin();
            a = (dl == 5) ? {{(ADDR_W-4){1'b1}}, 4'h0} : ADDR_W'($urandom) & ~ADDR_W'(1);
            for (int i = 0; i < $urandom_range(10, 40); i++) begin
                ioctl_write(a, 16'($urandom));
                if ($urandom_range(0, 4) == 0) a = ADDR_W'($urandom_range(0, 255)) & ~ADDR_W'(1);
                else a = a + ADDR_W'(2);
                if ($urandom_range(0, 2) == 0) tick($urandom_range(1, 3));
            end
            dl_end();
        end

        // Reset while a word is outstanding.
        dl_begin();
        ack_hold = 1'b1;
        for (int i = 0; i < 4; i++) ioctl_write(25'(2*i), 16'($urandom));
        begin
            int guard = 0;
            while (bus.mem_req !== 1'b1 && guard < 100) begin
                tick();
                guard++;
            end
            check("t5_req_before_reset", 128'(bus.mem_req), 128'(1));
        end
        #2;
        reset = 1'b1;
        bus.ioctl_download = 1'b0;
        #1;
        check("t5_rst_wait", 128'(bus.ioctl_wait), 128'(0));
        check("t5_rst_req", 128'(bus.mem_req), 128'(0));
        check("t5_rst_addr", 128'(bus.mem_addr), 128'(0));
        check("t5_rst_din", 128'(bus.mem_din), 128'(0));
        check("t5_rst_be", 128'(bus.mem_be), 128'(0));
        check("t5_rst_done", 128'(bus.done), 128'(0));
        exp_q.delete();
        m_be = '0;
        bus.mem_ack = 1'b0;
        tick(2);
        reset = 1'b0;
        ack_hold = 1'b0;
        tick(2);
        dl_begin();
        w0 = words_seen;
        ioctl_write(25'h20, 16'h5A5A);
        ioctl_write(25'h22, 16'hC3C3);
        dl_end();
        check("t5_words", 128'(words_seen - w0), 128'(1));
        check("t5_addr", 128'(last_addr), 128'(4));
        check("t5_be", 128'(last_be), 128'(8'h0F));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
